// File: rtl/clk_reset_sequencer_if.sv
// Supervisor bus between the reset sequencer and the clock-generator / system side.
// Pure wiring: no storage, no latency.
// No backpressure: every signal is a level or a single-cycle strobe.
//
// Ports (master = sequencer side):
//   clkLocked  in   combined generator lock, asynchronous to clk
//   rstReq     in   single-cycle request to restart sequencing
//   dcmRst     out  active-high reset to the generator
//   sysRstN    out  active-low system reset, high only in RUN
//   ready      out  high only in RUN
//   lockFail   out  high only in FAIL
//   retryCount out  failed attempts since the last clear
interface clk_reset_sequencer_if;
    logic       clkLocked;
    logic       rstReq;
    logic       dcmRst;
    logic       sysRstN;
    logic       ready;
    logic       lockFail;
    logic [3:0] retryCount;

    modport master (
        input  clkLocked,
        input  rstReq,
        output dcmRst,
        output sysRstN,
        output ready,
        output lockFail,
        output retryCount
    );

    modport slave (
        output clkLocked,
        output rstReq,
        input  dcmRst,
        input  sysRstN,
        input  ready,
        input  lockFail,
        input  retryCount
    );
endinterface

// File: rtl/clk_reset_sequencer.sv
// Reset supervisor: pulses the generator reset, qualifies lock, then releases system reset.
// Latency: lock seen 3 cycles after clkLocked rises; release after a further STABLE_CYCLES.
// No backpressure; rstReq is honoured in any state and overrides every other transition.
//
// Ports:
//   clk   raw oscillator clock (also feeds the generator)
//   rstN  asynchronous active-low reset
//   bus   clk_reset_sequencer_if.master: clkLocked/rstReq in, dcmRst/sysRstN/ready/
//         lockFail/retryCount out
module clk_reset_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rstN,
    clk_reset_sequencer_if.master        bus
);

    localparam logic [2:0] ST_DCM_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of a window of N cycles is N-1.
    localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRY);

    // Lock synchronizer: [0] is the metastability catcher, [1] is lockS.
    logic [1:0]           sync_q, sync_d;
    logic                 lock_s;

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           retry_q, retry_d;

    logic                 dcm_rst_q, dcm_rst_d;
    logic                 sys_rst_n_q, sys_rst_n_d;
    logic                 ready_q, ready_d;
    logic                 lock_fail_q, lock_fail_d;

    logic                 attempt_failed;
    logic [3:0]           retry_inc;
    logic                 state_entry;
    logic                 counting;

    always_comb begin
        sync_d = {sync_q[0], bus.clkLocked};
    end

    assign lock_s = sync_q[1];

    // Next-state logic. A failed attempt is flagged here and resolved below,
    // so WAIT_LOCK and STABLE share one retry/FAIL decision.
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        attempt_failed = 1'b0;

        case (state_q)
            ST_DCM_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins on the timeout cycle.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    attempt_failed = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                // retryCount is already 0 here, so a lock loss in RUN simply
                // re-sequences without being charged as a failure.
                if (!lock_s) begin
                    state_d = ST_DCM_RST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_DCM_RST;
            end
        endcase

        retry_inc = (retry_q >= RETRY_LIMIT) ? RETRY_LIMIT : retry_q + 4'd1;

        if (attempt_failed) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_DCM_RST;
        end

        if (bus.rstReq) begin
            state_d = ST_DCM_RST;
            retry_d = 4'd0;
        end
    end

    // Shared cycle counter. rstReq counts as an entry even when already in
    // DCM_RST so the generator pulse restarts at full width.
    always_comb begin
        state_entry = (state_d != state_q) || bus.rstReq;
        counting    = (state_q == ST_DCM_RST) || (state_q == ST_WAIT_LOCK) ||
                      (state_q == ST_STABLE);
        if (state_entry) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // moves on the same edge as its state transition and cannot glitch.
    always_comb begin
        dcm_rst_d   = (state_d == ST_DCM_RST);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        lock_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q      <= 2'b00;
            state_q     <= ST_DCM_RST;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            dcm_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            dcm_rst_q   <= dcm_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign bus.dcmRst     = dcm_rst_q;
    assign bus.sysRstN    = sys_rst_n_q;
    assign bus.ready      = ready_q;
    assign bus.lockFail   = lock_fail_q;
    assign bus.retryCount = retry_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: directed scenarios plus a per-cycle behavioural model.
// Model tracks phase with a countdown of remaining cycles and a 2-deep lock delay line.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_clk_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRY     = 3;
    localparam int CNT_WIDTH     = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   cyc    = 0;

    clk_reset_sequencer_if bus();

    clk_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rstN(rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: dut=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_PULSE   = 10;  // generator reset pulse
    localparam int PH_WAITING = 20;  // waiting for lock
    localparam int PH_QUALIFY = 30;  // lock qualification window
    localparam int PH_RUNNING = 40;
    localparam int PH_FAILED  = 50;

    int m_phase = PH_PULSE;
    int m_left  = RST_CYCLES;   // cycles remaining in the current window
    int m_retry = 0;
    bit m_l1    = 1'b0;         // lock delay line, m_l2 is what decisions see
    bit m_l2    = 1'b0;

    task automatic m_restart();
        m_phase = PH_PULSE;
        m_left  = RST_CYCLES;
    endtask

    task automatic m_failed_attempt();
        if (m_retry < MAX_RETRY) m_retry = m_retry + 1;
        if (m_retry == MAX_RETRY) m_phase = PH_FAILED;
        else m_restart();
    endtask

    task automatic m_step();
        bit seen;
        seen = m_l2;
        m_l2 = m_l1;
        m_l1 = bus.clkLocked;
        if (bus.rstReq) begin
            m_restart();
            m_retry = 0;
        end else begin
            case (m_phase)
                PH_PULSE: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = PH_WAITING;
                        m_left  = LOCK_TIMEOUT;
                    end
                end
                PH_WAITING: begin
                    if (seen) begin
                        m_phase = PH_QUALIFY;
                        m_left  = STABLE_CYCLES;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_failed_attempt();
                    end
                end
                PH_QUALIFY: begin
                    if (!seen) m_failed_attempt();
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_phase = PH_RUNNING;
                            m_retry = 0;
                        end
                    end
                end
                PH_RUNNING: if (!seen) m_restart();
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_restart();
            m_retry = 0;
            m_l1    = 1'b0;
            m_l2    = 1'b0;
        end else begin
            m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model dcmRst",     int'(bus.dcmRst),     int'(m_phase == PH_PULSE));
            check("model sysRstN",    int'(bus.sysRstN),    int'(m_phase == PH_RUNNING));
            check("model ready",      int'(bus.ready),      int'(m_phase == PH_RUNNING));
            check("model lockFail",   int'(bus.lockFail),   int'(m_phase == PH_FAILED));
            check("model retryCount", int'(bus.retryCount), m_retry);
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int rise[$];
        int fail_cyc;
        bit prev;

        bus.clkLocked = 1'b0;
        bus.rstReq    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;

        // Reset state
        check("reset dcmRst",     int'(bus.dcmRst),     1);
        check("reset sysRstN",    int'(bus.sysRstN),    0);
        check("reset ready",      int'(bus.ready),      0);
        check("reset lockFail",   int'(bus.lockFail),   0);
        check("reset retryCount", int'(bus.retryCount), 0);

        // Clean bring-up
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.dcmRst && n < 50);
        check("bringup dcmRst width", n, 4);
        repeat (20) @(negedge clk);
        bus.clkLocked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.sysRstN && n < 100);
        check("bringup release latency", n, 19);
        check("bringup ready",      int'(bus.ready),      1);
        check("bringup retryCount", int'(bus.retryCount), 0);

        // Lock loss in RUN
        repeat (5) @(negedge clk);
        bus.clkLocked = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.sysRstN && n < 20);
        check("runloss latency",    n, 3);
        check("runloss dcmRst",     int'(bus.dcmRst),     1);
        check("runloss ready",      int'(bus.ready),      0);
        check("runloss retryCount", int'(bus.retryCount), 0);
        bus.clkLocked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.sysRstN && n < 100);
        check("runloss relock latency", n, 21);
        check("runloss relock retry", int'(bus.retryCount), 0);

        // Lock glitch in STABLE
        repeat (3) @(negedge clk);
        bus.rstReq = 1'b1;
        @(negedge clk);
        bus.rstReq = 1'b0;
        check("rstReq from RUN dcmRst",  int'(bus.dcmRst),  1);
        check("rstReq from RUN sysRstN", int'(bus.sysRstN), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.dcmRst && n < 20);
        check("rstReq pulse remainder", n, 4);
        repeat (9) @(negedge clk);
        bus.clkLocked = 1'b0;
        repeat (2) @(negedge clk);
        bus.clkLocked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.dcmRst && n < 20);
        check("glitch detect latency", n, 1);
        check("glitch retryCount",     int'(bus.retryCount), 1);
        check("glitch sysRstN",        int'(bus.sysRstN),    0);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.dcmRst && n < 20);
        check("glitch repulse width",  n, 4);
        check("glitch sysRstN after",  int'(bus.sysRstN), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.sysRstN && n < 100);
        check("glitch recovery latency", n, 17);
        check("glitch retry cleared",    int'(bus.retryCount), 0);

        // Async reset mid-STABLE
        repeat (3) @(negedge clk);
        bus.rstReq = 1'b1;
        @(negedge clk);
        bus.rstReq = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.dcmRst && n < 20);
        repeat (5) @(negedge clk);
        check("pre-async dcmRst", int'(bus.dcmRst), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async dcmRst",   int'(bus.dcmRst),   1);
        check("async sysRstN",  int'(bus.sysRstN),  0);
        check("async ready",    int'(bus.ready),    0);
        check("async lockFail", int'(bus.lockFail), 0);
        check("async retry",    int'(bus.retryCount), 0);
        #1 rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.dcmRst && n < 20);
        check("async restart dcmRst width", n, 4);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.sysRstN && n < 100);
        check("async restart release", n, 17);

        // Timeout to FAIL
        repeat (3) @(negedge clk);
        bus.clkLocked = 1'b0;
        prev = bus.dcmRst;
        fail_cyc = 0;
        n = 0;
        while (!bus.lockFail && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.dcmRst && !prev) rise.push_back(cyc);
            prev = bus.dcmRst;
        end
        fail_cyc = cyc;
        check("timeout pulse count", rise.size(), 3);
        for (int i = 1; i < rise.size(); i++) begin
            check("timeout pulse spacing", rise[i] - rise[i-1], RST_CYCLES + LOCK_TIMEOUT);
        end
        if (rise.size() == 3) begin
            check("timeout final attempt", fail_cyc - rise[2], 104);
        end
        check("timeout lockFail",   int'(bus.lockFail),   1);
        check("timeout retryCount", int'(bus.retryCount), 3);
        check("timeout dcmRst",     int'(bus.dcmRst),     0);
        repeat (30) @(negedge clk);
        check("fail sticky lockFail", int'(bus.lockFail), 1);
        check("fail sticky dcmRst",   int'(bus.dcmRst),   0);

        // Recovery from FAIL
        bus.rstReq = 1'b1;
        @(negedge clk);
        bus.rstReq = 1'b0;
        check("recover lockFail",   int'(bus.lockFail),   0);
        check("recover retryCount", int'(bus.retryCount), 0);
        check("recover dcmRst",     int'(bus.dcmRst),     1);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_reset_sequencer.md
# clk_reset_sequencer

Reset supervisor for the clock-generator chain. Runs on the raw board oscillator, pulses the generator's DCM reset, and waits for the generator's combined lock flag. It then requires lock to stay high for a qualification window before releasing the system reset. Lock loss triggers an automatic re-sequence, and lock timeouts are retried a bounded number of times before the block reports a hard failure.

## Interface
- RST_CYCLES, 4: cycles `dcmRst` is held high per attempt; minimum 3.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before the attempt is declared failed.
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release.
- MAX_RETRY, 3: failed attempts allowed before FAIL; range 1..15.
- CNT_WIDTH, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- clk  in  1  raw oscillator clock; the same net that drives the generator's raw clock input.
- rstN  in  1  asynchronous, active-low reset.
- clkLocked  in  1  combined lock from the clock generator; asynchronous to `clk`.
- rstReq  in  1  synchronous single-cycle request to restart sequencing.
- dcmRst  out  1  active-high reset to the generator's raw reset input.
- sysRstN  out  1  active-low system reset; high only in RUN.
- ready  out  1  high only in RUN.
- lockFail  out  1  high only in FAIL.
- retryCount  out  4  failed attempts since the last clear.

## Operation
- `clkLocked` passes through a 2-flop synchronizer to give `lockS`. All decisions use `lockS`.
- States: DCM_RST, WAIT_LOCK, STABLE, RUN, FAIL. One counter `cnt` is cleared on every state entry.
- DCM_RST: `dcmRst`=1. At `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `lockS`=1: go to STABLE.
  - `lockS`=0 at `cnt`==LOCK_TIMEOUT-1: failed attempt.
  - `lockS`=1 on the timeout cycle: lock wins.
- STABLE:
  - `lockS`=0: failed attempt.
  - `lockS`=1 at `cnt`==STABLE_CYCLES-1: go to RUN and clear `retryCount`.
- Failed attempt: `retryCount`+1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to DCM_RST.
- RUN: `sysRstN`=1, `ready`=1. `lockS`=0 goes to DCM_RST; this does not count as a failure because `retryCount` is 0 on entry.
- FAIL: `lockFail`=1, `dcmRst`=0. Only `rstN` or `rstReq` leaves this state.
- `rstReq`=1 in any state: go to DCM_RST, clear `retryCount` and `cnt`. It overrides every other transition in the same cycle.
- `retryCount` saturates at MAX_RETRY.

## Timing
- Reset values while `rstN`=0:
  - state DCM_RST, `cnt`=0, `retryCount`=0
  - `dcmRst`=1, `sysRstN`=0, `ready`=0, `lockFail`=0
  - both synchronizer flops 0
- All outputs are registered and decoded from the state register (Moore). An output changes on the same edge as its state transition.
- `dcmRst` stays high for exactly RST_CYCLES edges after `rstN` rises, or after entering DCM_RST.
- Lock recognition takes 2 cycles of synchronizer latency plus 1 cycle for the state update.
- Release latency, counted from the `clkLocked` rise while in WAIT_LOCK to `sysRstN` rising, is 3 + STABLE_CYCLES cycles.
- Lock loss in RUN: `sysRstN` and `ready` fall 3 cycles after `clkLocked` falls, on the same edge `dcmRst` rises.
- `sysRstN` never glitches high outside RUN. The reset is released synchronously to `clk` and asserted asynchronously via `rstN`.
- Total timeout per attempt is RST_CYCLES + LOCK_TIMEOUT cycles.

## Test plan
All scenarios use bench parameters RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=3.
- Clean bring-up: release `rstN`, raise `clkLocked` 20 cycles after `dcmRst` falls. Require `dcmRst` high for 4 cycles and `sysRstN`=`ready`=1 exactly 19 cycles after the lock rise, with `retryCount`=0.
- Lock glitch in STABLE: drop `clkLocked` for 2 cycles, 8 cycles into STABLE. Require `retryCount`=1, `dcmRst` re-pulsed for 4 cycles, and `sysRstN` still 0.
- Timeout to FAIL: keep `clkLocked`=0. Require 3 `dcmRst` pulses spaced 104 cycles apart, `retryCount` reaching 3, `lockFail`=1, and `dcmRst`=0 afterwards.
- Recovery from FAIL: pulse `rstReq` for 1 cycle. Require `lockFail`=0, `retryCount`=0, and `dcmRst`=1 on the next edge.
- Lock loss in RUN: drop `clkLocked`. Require `sysRstN`=0 and `dcmRst`=1 3 cycles later, `retryCount` stays 0, and re-lock reaches RUN again.
- Async reset mid-STABLE: pulse `rstN` low for a fraction of a cycle. Require all outputs to take their reset values immediately, without waiting for a clock edge, and the sequence to restart from DCM_RST.
